// File: rtl/mips_pkg.sv
// Shared widths and constants for the MIPS register file and scoreboard.
package mips_pkg;

    localparam int unsigned MIPS_DATA_W = 32;
    localparam int unsigned MIPS_ADDR_W = 5;
    localparam int unsigned MIPS_PEND_W = 2;

    // Index of the hardwired-zero register.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/mips_scoreboard.sv
// Per-register pending-write counters.
// Drives issue back-pressure, per-port read hazards and a sticky
// "writeback without reservation" error flag.
module mips_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = MIPS_ADDR_W,
    parameter int unsigned PEND_W = MIPS_PEND_W,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] read_reg,
    output logic [NUM_RD-1:0]        read_hazard,
    input  logic                     signal_reg_write,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_reg,
    output logic                     issue_ready,
    output logic                     sb_error
);

    localparam int unsigned        NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0] pend [NREGS];
    logic              issue_acc;
    logic              wb_nz;
    logic [NREGS-1:0]  inc_hit;
    logic [NREGS-1:0]  dec_hit;

    // Back-pressure depends only on the addressed counter, never on issue_valid.
    assign issue_ready = !((issue_reg != ZERO_IDX) && (pend[issue_reg] == PEND_MAX));
    assign issue_acc   = issue_valid && issue_ready && (issue_reg != ZERO_IDX);
    assign wb_nz       = signal_reg_write && (write_reg != ZERO_IDX);

    // Decode which counter is bumped up by an issue and which down by a writeback.
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        if (issue_acc) begin
            inc_hit[issue_reg] = 1'b1;
        end
        if (wb_nz) begin
            dec_hit[write_reg] = 1'b1;
        end
    end

    // Counter update: a same-register issue and writeback cancel out; no wrap either way.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                pend[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (inc_hit[r] && !dec_hit[r]) begin
                    pend[r] <= pend[r] + PEND_ONE;
                end else if (dec_hit[r] && !inc_hit[r] && (pend[r] != '0)) begin
                    pend[r] <= pend[r] - PEND_ONE;
                end
            end
        end
    end

    // Sticky error on a writeback that finds no reservation to retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_error <= 1'b0;
        end else if (wb_nz && (pend[write_reg] == '0) && !inc_hit[write_reg]) begin
            sb_error <= 1'b1;
        end
    end

    // A read is hazardous unless its last outstanding write retires this cycle.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_haz
        logic [ADDR_W-1:0] idx;
        assign idx = read_reg[k*ADDR_W +: ADDR_W];
        assign read_hazard[k] = (idx != ZERO_IDX) &&
                                ((pend[idx] > PEND_ONE) ||
                                 ((pend[idx] == PEND_ONE) && !dec_hit[idx]));
    end

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS register file with write-through bypass and an attached
// pending-write scoreboard. Register 0 is hardwired to zero.
module mips_regfile_sb
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = MIPS_DATA_W,
    parameter int unsigned ADDR_W = MIPS_ADDR_W,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned PEND_W = MIPS_PEND_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_hazard,
    input  logic                     signal_reg_write,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_reg,
    output logic                     issue_ready,
    output logic                     sb_error
);

    localparam int unsigned        NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_en;

    assign wr_en = signal_reg_write && (write_reg != ZERO_IDX);

    // Register storage; index 0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // Combinational read ports with same-cycle writeback forwarding.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        assign idx = read_reg[k*ADDR_W +: ADDR_W];
        assign read_data[k*DATA_W +: DATA_W] =
            (idx == ZERO_IDX)                ? '0         :
            (wr_en && (write_reg == idx))    ? write_data :
                                               regs[idx];
    end

    mips_scoreboard #(
        .ADDR_W (ADDR_W),
        .PEND_W (PEND_W),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk              (clk),
        .rst              (rst),
        .read_reg         (read_reg),
        .read_hazard      (read_hazard),
        .signal_reg_write (signal_reg_write),
        .write_reg        (write_reg),
        .issue_valid      (issue_valid),
        .issue_reg        (issue_reg),
        .issue_ready      (issue_ready),
        .sb_error         (sb_error)
    );

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Self-checking bench for mips_regfile_sb: a vector table plus hand-built
// sequences, with expectations queued at drive time and checked on sample.
module tb_mips_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  read_reg;
    logic [63:0] read_data;
    logic [1:0]  read_hazard;
    logic        signal_reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        issue_ready;
    logic        sb_error;

    int n_tests = 0;
    int n_fail  = 0;

    typedef enum {K_RD0, K_RD1, K_HAZ, K_RDY, K_ERR} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        iv;
        logic [4:0]  ireg;
        logic [4:0]  rr0;
        logic [4:0]  rr1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_haz;
        logic        e_rdy;
        logic        e_err;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[12];

    mips_regfile_sb #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .PEND_W (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .read_reg         (read_reg),
        .read_data        (read_data),
        .read_hazard      (read_hazard),
        .signal_reg_write (signal_reg_write),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .issue_valid      (issue_valid),
        .issue_reg        (issue_reg),
        .issue_ready      (issue_ready),
        .sb_error         (sb_error)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wreg,
                                input logic [31:0] wdata, input logic iv, input logic [4:0] ireg,
                                input logic [4:0] rr0, input logic [4:0] rr1,
                                input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                                input logic [1:0] e_haz, input logic e_rdy, input logic e_err);
        vec_t v;
        v.rst = r;   v.we = we;     v.wreg = wreg;   v.wdata = wdata;
        v.iv = iv;   v.ireg = ireg; v.rr0 = rr0;     v.rr1 = rr1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_haz = e_haz;
        v.e_rdy = e_rdy; v.e_err = e_err;
        return v;
    endfunction

    function automatic logic [31:0] actual_of(input kind_t k);
        case (k)
            K_RD0:   return read_data[31:0];
            K_RD1:   return read_data[63:32];
            K_HAZ:   return {30'b0, read_hazard};
            K_RDY:   return {31'b0, issue_ready};
            default: return {31'b0, sb_error};
        endcase
    endfunction

    task automatic push(input kind_t k, input logic [31:0] val, input string tag);
        exp_t e;
        e.kind = k;
        e.val  = val;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = actual_of(e.kind);
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h", e.tag, act, e.val);
            end
        end
    endtask

    // Drive one cycle of inputs mid-period, queue expectations, sample before the edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        rst              = v.rst;
        signal_reg_write = v.we;
        write_reg        = v.wreg;
        write_data       = v.wdata;
        issue_valid      = v.iv;
        issue_reg        = v.ireg;
        read_reg         = {v.rr1, v.rr0};
        push(K_RD0, v.e_rd0,            {tag, ".rd0"});
        push(K_RD1, v.e_rd1,            {tag, ".rd1"});
        push(K_HAZ, {30'b0, v.e_haz},   {tag, ".hazard"});
        push(K_RDY, {31'b0, v.e_rdy},   {tag, ".ready"});
        push(K_ERR, {31'b0, v.e_err},   {tag, ".sb_error"});
        #1;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        signal_reg_write = 1'b0;
        write_reg        = '0;
        write_data       = '0;
        issue_valid      = 1'b0;
        issue_reg        = '0;
        read_reg         = '0;
        repeat (2) @(posedge clk);

        //            rst we wreg wdata         iv ireg rr0 rr1  e_rd0         e_rd1         haz    rdy err
        tbl[0]  = mk(0, 0, 0,  32'h0,        0, 0, 5,  0,  32'h0,        32'h0,        2'b00, 1, 0);
        tbl[1]  = mk(0, 1, 5,  32'hDEADBEEF, 1, 5, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 0);
        tbl[2]  = mk(0, 0, 0,  32'h0,        0, 0, 5,  3,  32'hDEADBEEF, 32'h0,        2'b00, 1, 0);
        tbl[3]  = mk(0, 1, 0,  32'hFFFFFFFF, 1, 0, 0,  0,  32'h0,        32'h0,        2'b00, 1, 0);
        tbl[4]  = mk(0, 0, 0,  32'h0,        0, 0, 0,  0,  32'h0,        32'h0,        2'b00, 1, 0);
        tbl[5]  = mk(0, 1, 12, 32'hA5A50C0C, 0, 0, 12, 5,  32'hA5A50C0C, 32'hDEADBEEF, 2'b00, 1, 0);
        tbl[6]  = mk(0, 0, 0,  32'h0,        0, 0, 12, 0,  32'hA5A50C0C, 32'h0,        2'b00, 1, 1);
        tbl[7]  = mk(0, 0, 0,  32'h0,        1, 3, 12, 5,  32'hA5A50C0C, 32'hDEADBEEF, 2'b00, 1, 1);
        tbl[8]  = mk(0, 1, 3,  32'h1234,     1, 3, 3,  3,  32'h1234,     32'h1234,     2'b00, 1, 1);
        tbl[9]  = mk(0, 0, 0,  32'h0,        1, 3, 3,  0,  32'h1234,     32'h0,        2'b01, 1, 1);
        tbl[10] = mk(1, 1, 3,  32'hFFFF,     1, 3, 3,  12, 32'hFFFF,     32'hA5A50C0C, 2'b01, 1, 1);
        tbl[11] = mk(0, 0, 0,  32'h0,        0, 3, 3,  12, 32'h0,        32'h0,        2'b00, 1, 0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Saturate reg 7, get refused, then drain it with three writebacks.
        step(mk(0, 0, 0, 32'h0,  1, 7, 0, 7, 32'h0, 32'h0,  2'b00, 1, 0), "sat.iss1");
        step(mk(0, 0, 0, 32'h0,  1, 7, 0, 7, 32'h0, 32'h0,  2'b10, 1, 0), "sat.iss2");
        step(mk(0, 0, 0, 32'h0,  1, 7, 0, 7, 32'h0, 32'h0,  2'b10, 1, 0), "sat.iss3");
        step(mk(0, 0, 0, 32'h0,  1, 7, 0, 7, 32'h0, 32'h0,  2'b10, 0, 0), "sat.iss4");
        step(mk(0, 1, 7, 32'h77, 0, 7, 0, 7, 32'h0, 32'h77, 2'b10, 0, 0), "sat.wb1");
        step(mk(0, 1, 7, 32'h78, 0, 7, 0, 7, 32'h0, 32'h78, 2'b10, 1, 0), "sat.wb2");
        step(mk(0, 1, 7, 32'h79, 0, 7, 0, 7, 32'h0, 32'h79, 2'b00, 1, 0), "sat.wb3");
        step(mk(0, 0, 0, 32'h0,  0, 7, 0, 7, 32'h0, 32'h79, 2'b00, 1, 0), "sat.idle");

        // Same-cycle issue+writeback on reg 9, stray writeback on reg 12, then reset.
        step(mk(0, 0, 0,  32'h0,      1, 9, 9, 12, 32'h0,  32'h0,      2'b00, 1, 0), "co.iss");
        step(mk(0, 1, 9,  32'h99,     1, 9, 9, 12, 32'h99, 32'h0,      2'b00, 1, 0), "co.both");
        step(mk(0, 0, 0,  32'h0,      0, 0, 9, 12, 32'h99, 32'h0,      2'b01, 1, 0), "co.after");
        step(mk(0, 1, 12, 32'hC0FFEE, 0, 0, 9, 12, 32'h99, 32'hC0FFEE, 2'b01, 1, 0), "err.wb");
        step(mk(0, 0, 0,  32'h0,      0, 0, 9, 12, 32'h99, 32'hC0FFEE, 2'b01, 1, 1), "err.set");
        step(mk(0, 1, 9,  32'h9A,     0, 0, 9, 12, 32'h9A, 32'hC0FFEE, 2'b00, 1, 1), "err.hold1");
        step(mk(0, 0, 0,  32'h0,      0, 0, 9, 12, 32'h9A, 32'hC0FFEE, 2'b00, 1, 1), "err.hold2");
        step(mk(1, 0, 0,  32'h0,      0, 0, 9, 12, 32'h9A, 32'hC0FFEE, 2'b00, 1, 1), "err.rst");
        step(mk(0, 0, 0,  32'h0,      0, 0, 9, 12, 32'h0,  32'h0,      2'b00, 1, 0), "err.clr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_regfile_sb.md
MIPS_REGFILE_SB -- requirements
Module: mips_regfile_sb

Interface
REQ-001 Parameter DATA_W, 32, register data width in bits.
REQ-002 Parameter ADDR_W, 5, register index width; register count NREGS = 2**ADDR_W.
REQ-003 Parameter NUM_RD, 2, number of read ports (1..4).
REQ-004 Parameter PEND_W, 2, width of the per-register pending-write counter; maximum in-flight writes per register = 2**PEND_W-1.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 read_reg  in  NUM_RD*ADDR_W  packed read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 read_data  out  NUM_RD*DATA_W  packed read data, same packing as read_reg.
REQ-009 read_hazard  out  NUM_RD  bit k=1: register on port k has an unresolved pending write.
REQ-010 signal_reg_write  in  1  writeback strobe.
REQ-011 write_reg  in  ADDR_W  writeback destination index.
REQ-012 write_data  in  DATA_W  writeback data.
REQ-013 issue_valid  in  1  request to reserve a destination register for an issuing instruction.
REQ-014 issue_reg  in  ADDR_W  destination index to reserve.
REQ-015 issue_ready  out  1  reservation accepted this cycle when issue_valid=1.
REQ-016 sb_error  out  1  sticky flag: writeback arrived for a register with no pending reservation.

Function
REQ-017 Register 0 SHALL read 0 on every port; writes and reservations to index 0 SHALL be ignored and never raise sb_error.
REQ-018 Reads SHALL be combinational (zero latency) from register storage.
REQ-019 Write-through bypass: when signal_reg_write=1 and write_reg equals a nonzero read index, that port SHALL return write_data in the same cycle.
REQ-020 A write with signal_reg_write=1 SHALL update storage at the next rising edge of clk.
REQ-021 Each nonzero register SHALL own a PEND_W-bit counter pend[r].
REQ-022 issue_ready SHALL be 1 unless issue_reg is nonzero and pend[issue_reg] equals its maximum value; issue_ready SHALL NOT depend on issue_valid.
REQ-023 Accepted issue (issue_valid & issue_ready, nonzero index) SHALL increment pend[issue_reg].
REQ-024 Writeback to nonzero write_reg with pend>0 SHALL decrement pend[write_reg].
REQ-025 Simultaneous accepted issue and writeback to the same register SHALL leave pend unchanged and SHALL NOT raise sb_error, including when pend=0.
REQ-026 Writeback to nonzero register with pend=0 (no same-register issue that cycle) SHALL still write storage, SHALL leave pend at 0 and SHALL set sb_error at the next edge.
REQ-027 read_hazard[k] SHALL be 1 iff index k is nonzero and pend>1, or pend=1 with no same-cycle writeback to that index.
REQ-028 The counter SHALL never wrap: no increment at maximum, no decrement at zero.
REQ-029 sb_error SHALL remain set until rst.

Reset
REQ-030 While rst=1 at a rising edge, all registers SHALL clear to 0, all pend counters to 0 and sb_error to 0; writes and issues in that cycle SHALL be discarded.
REQ-031 After reset: read_data all 0, read_hazard all 0, issue_ready=1, sb_error=0.
REQ-032 rst asserted with writes in flight SHALL drop every reservation; there is no recovery of pending state.

Structure
REQ-033 Default widths (DATA_W, ADDR_W, PEND_W) and the zero-register index constant SHALL live in the shared package mips_pkg.
REQ-034 The pending counters, issue_ready, read_hazard and sb_error SHALL form the sub-module mips_scoreboard; mips_regfile_sb contains storage, bypass and the instance.

Verification
REQ-035 Reset, then write reg 5 = 0xDEADBEEF, read on port 0 in the same cycle -> 0xDEADBEEF via bypass; next cycle -> 0xDEADBEEF from storage.
REQ-036 Write reg 0 = 0xFFFFFFFF, then read reg 0 on all ports -> 0; issue reg 0 -> issue_ready=1, read_hazard=0.
REQ-037 Issue reg 7 three times (PEND_W=2) -> issue_ready=0 on fourth attempt; three writebacks -> read_hazard[1]=0 in the third writeback cycle.
REQ-038 Issue and writeback reg 9 in the same cycle with pend=1 -> pend stays 1, read_hazard=1, sb_error=0.
REQ-039 Writeback reg 12 with pend=0 -> storage updated, sb_error=1 next cycle, stays 1 until rst.
REQ-040 Assert rst with pend[3]=2 and reg 3=0x1234 -> after the edge: reg 3 reads 0, read_hazard=0, issue_ready=1.
